// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: condition codes,
// flag bit positions and the branch-condition evaluator.
package pc_seq_pkg;

    localparam logic [2:0] COND_NEVER  = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_C      = 3'b011;
    localparam logic [2:0] COND_NC     = 3'b100;
    localparam logic [2:0] COND_S      = 3'b101;
    localparam logic [2:0] COND_NS     = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;

    function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] flags);
        logic res;
        res = 1'b0;
        case (cond)
            COND_NEVER:  res = 1'b0;
            COND_Z:      res = flags[FLAG_Z];
            COND_NZ:     res = ~flags[FLAG_Z];
            COND_C:      res = flags[FLAG_C];
            COND_NC:     res = ~flags[FLAG_C];
            COND_S:      res = flags[FLAG_S];
            COND_NS:     res = ~flags[FLAG_S];
            COND_ALWAYS: res = 1'b1;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for call/return. dout is the combinational top of stack;
// pushes into a full stack and pops from an empty one are dropped and flagged.
module ret_stack #(
    parameter int AW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          udf
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]   sp;
    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    assign wr_idx  = sp[PW-1:0];
    assign rd_idx  = wr_idx - PW'(1);
    assign empty   = (sp == '0);
    assign full    = (sp == (PW+1)'(DEPTH));
    // A simultaneous push is ignored when popping; the owner never relies on both.
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~pop & ~full;
    assign ovf     = push & ~pop & full;
    assign udf     = pop & empty;
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (do_pop) begin
            sp <= sp - (PW+1)'(1);
        end else if (do_push) begin
            sp <= sp + (PW+1)'(1);
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC selection and call/return stack.
// Optional taken-branch counter output br_count enabled by defining PC_SEQ_BRCNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              AW       = 32,
    parameter int              DEPTH    = 8,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [AW-1:0] address,
    input  logic [AW-1:0] alu_result,
    input  logic          ad_sel,
    input  logic          uncond,
    input  logic [2:0]    cond,
    input  logic [2:0]    flags,
    input  logic          call,
    input  logic          ret,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] next_pc,
    output logic          taken,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          stk_err
`ifdef PC_SEQ_BRCNT_EN
    ,
    output logic [31:0]   br_count
`endif
);

    logic [AW-1:0] seq;
    logic [AW-1:0] target;
    logic [AW-1:0] tos;
    logic          jump;
    logic          push;
    logic          pop;
    logic          ovf;
    logic          udf;

    assign seq    = pc + AW'(PC_STEP);
    assign target = ad_sel ? alu_result : address;
    assign jump   = uncond | cond_eval(cond, flags) | call;
    // ret overrides call entirely, so a call is only pushed when ret is low.
    assign push   = en & call & ~ret;
    assign pop    = en & ret;

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (seq),
        .dout  (tos),
        .empty (stk_empty),
        .full  (stk_full),
        .ovf   (ovf),
        .udf   (udf)
    );

    // taken follows the selected source, not a value compare against seq.
    always_comb begin
        next_pc = seq;
        taken   = 1'b0;
        if (ret) begin
            if (!stk_empty) begin
                next_pc = tos;
                taken   = 1'b1;
            end
        end else if (jump) begin
            next_pc = target;
            taken   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            stk_err <= 1'b0;
        end else if (en) begin
            pc      <= next_pc;
            stk_err <= stk_err | ovf | udf;
        end
    end

`ifdef PC_SEQ_BRCNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count <= '0;
        end else if (en && taken) begin
            br_count <= sat_inc(br_count);
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: condition-code table plus call/return,
// stack overflow/underflow, priority, stall, wrap and optional counter sequences.
module tb_pc_sequencer;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] address;
    logic [AW-1:0] alu_result;
    logic          ad_sel;
    logic          uncond;
    logic [2:0]    cond;
    logic [2:0]    flags;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc;
    logic [AW-1:0] next_pc;
    logic          taken;
    logic          stk_empty;
    logic          stk_full;
    logic          stk_err;
`ifdef PC_SEQ_BRCNT_EN
    logic [31:0]   br_count;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .PC_STEP  (1),
        .RESET_PC (32'h100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .address    (address),
        .alu_result (alu_result),
        .ad_sel     (ad_sel),
        .uncond     (uncond),
        .cond       (cond),
        .flags      (flags),
        .call       (call),
        .ret        (ret),
        .pc         (pc),
        .next_pc    (next_pc),
        .taken      (taken),
        .stk_empty  (stk_empty),
        .stk_full   (stk_full),
        .stk_err    (stk_err)
`ifdef PC_SEQ_BRCNT_EN
        ,
        .br_count   (br_count)
`endif
    );

    typedef struct {
        logic [2:0]  cond;
        logic [2:0]  flags;
        logic        ad_sel;
        logic        exp_taken;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        en         = 1'b1;
        address    = '0;
        alu_result = '0;
        ad_sel     = 1'b0;
        uncond     = 1'b0;
        cond       = 3'b000;
        flags      = 3'b000;
        call       = 1'b0;
        ret        = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        set_idle();
        uncond  = 1'b1;
        address = a;
        step();
        set_idle();
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        vec[0]  = '{3'b000, 3'b111, 1'b0, 1'b0, 32'h21};
        vec[1]  = '{3'b001, 3'b001, 1'b0, 1'b1, 32'h40};
        vec[2]  = '{3'b001, 3'b000, 1'b0, 1'b0, 32'h21};
        vec[3]  = '{3'b001, 3'b111, 1'b0, 1'b1, 32'h40};
        vec[4]  = '{3'b010, 3'b000, 1'b0, 1'b1, 32'h40};
        vec[5]  = '{3'b010, 3'b001, 1'b0, 1'b0, 32'h21};
        vec[6]  = '{3'b011, 3'b010, 1'b0, 1'b1, 32'h40};
        vec[7]  = '{3'b011, 3'b101, 1'b0, 1'b0, 32'h21};
        vec[8]  = '{3'b100, 3'b000, 1'b0, 1'b1, 32'h40};
        vec[9]  = '{3'b100, 3'b010, 1'b0, 1'b0, 32'h21};
        vec[10] = '{3'b101, 3'b100, 1'b0, 1'b1, 32'h40};
        vec[11] = '{3'b101, 3'b011, 1'b0, 1'b0, 32'h21};
        vec[12] = '{3'b110, 3'b011, 1'b0, 1'b1, 32'h40};
        vec[13] = '{3'b110, 3'b100, 1'b0, 1'b0, 32'h21};
        vec[14] = '{3'b111, 3'b000, 1'b0, 1'b1, 32'h40};
        vec[15] = '{3'b111, 3'b000, 1'b1, 1'b1, 32'h80};
        vec[16] = '{3'b000, 3'b000, 1'b1, 1'b0, 32'h21};
        vec[17] = '{3'b101, 3'b111, 1'b1, 1'b1, 32'h80};

        // Reset state and sequential stepping
        set_idle();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_pc", pc, 32'h100);
        chk("rst_empty", stk_empty, 1'b1);
        chk("rst_full", stk_full, 1'b0);
        chk("rst_err", stk_err, 1'b0);
        rst_n = 1'b1;
        step();
        chk("seq1", pc, 32'h101);
        step();
        chk("seq2", pc, 32'h102);
        step();
        chk("seq3", pc, 32'h103);
        chk("seq_taken", taken, 1'b0);
        chk("seq_next", next_pc, 32'h104);

        // Underflow after reset
        ret = 1'b1;
        #1;
        chk("udf_taken", taken, 1'b0);
        chk("udf_next", next_pc, 32'h104);
        step();
        chk("udf_pc", pc, 32'h104);
        chk("udf_err", stk_err, 1'b1);
        chk("udf_empty", stk_empty, 1'b1);

        // Asynchronous reset mid-operation
        set_idle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'h100);
        chk("async_rst_err", stk_err, 1'b0);
        #2;
        rst_n = 1'b1;

        // Condition-code table
        for (int i = 0; i < NV; i++) begin
            jump_to(32'h20);
            cond       = vec[i].cond;
            flags      = vec[i].flags;
            ad_sel     = vec[i].ad_sel;
            address    = 32'h40;
            alu_result = 32'h80;
            #1;
            chk($sformatf("cond_vec%0d_taken", i), taken, vec[i].exp_taken);
            step();
            chk($sformatf("cond_vec%0d_pc", i), pc, vec[i].exp_pc);
            set_idle();
        end

        // Call then immediate return
        jump_to(32'h10);
        call       = 1'b1;
        ad_sel     = 1'b1;
        alu_result = 32'h200;
        #1;
        chk("call_taken", taken, 1'b1);
        chk("call_next", next_pc, 32'h200);
        step();
        chk("call_pc", pc, 32'h200);
        chk("call_empty", stk_empty, 1'b0);
        set_idle();
        ret = 1'b1;
        #1;
        chk("ret_next", next_pc, 32'h11);
        chk("ret_taken", taken, 1'b1);
        step();
        chk("ret_pc", pc, 32'h11);
        chk("ret_empty", stk_empty, 1'b1);

        // call+ret+uncond together: pop only
        set_idle();
        call    = 1'b1;
        address = 32'h300;
        step();
        chk("prio_setup_pc", pc, 32'h300);
        set_idle();
        call    = 1'b1;
        ret     = 1'b1;
        uncond  = 1'b1;
        cond    = 3'b111;
        address = 32'h500;
        #1;
        chk("prio_next", next_pc, 32'h12);
        step();
        chk("prio_pc", pc, 32'h12);
        chk("prio_empty", stk_empty, 1'b1);
        chk("prio_err", stk_err, 1'b0);

        // Stall holds pc and stack, including a stalled call
        set_idle();
        call    = 1'b1;
        address = 32'h400;
        step();
        set_idle();
        en      = 1'b0;
        uncond  = 1'b1;
        address = 32'h999;
        #1;
        chk("stall_taken", taken, 1'b1);
        chk("stall_next", next_pc, 32'h999);
        step();
        call = 1'b1;
        step();
        call = 1'b0;
        step();
        chk("stall_pc", pc, 32'h400);
        chk("stall_empty", stk_empty, 1'b0);
        set_idle();
        ret = 1'b1;
        step();
        chk("stall_ret_pc", pc, 32'h13);
        chk("stall_ret_empty", stk_empty, 1'b1);

        // Overflow: DEPTH+1 nested calls
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_idle();
            call    = 1'b1;
            address = 32'h1000 + i;
            step();
        end
        chk("ovf_full_before", stk_full, 1'b1);
        chk("ovf_err_before", stk_err, 1'b0);
        set_idle();
        call    = 1'b1;
        address = 32'h1004;
        #1;
        chk("ovf_taken", taken, 1'b1);
        step();
        chk("ovf_pc", pc, 32'h1004);
        chk("ovf_full", stk_full, 1'b1);
        chk("ovf_err", stk_err, 1'b1);
        set_idle();
        ret = 1'b1;
        step();
        chk("ovf_ret_pc", pc, 32'h1003);
        chk("ovf_ret_full", stk_full, 1'b0);
        chk("ovf_err_sticky", stk_err, 1'b1);

        // Wrap and equal-value taken
        jump_to(32'hFFFF_FFFF);
        chk("wrap_setup", pc, 32'hFFFF_FFFF);
        #1;
        chk("wrap_next", next_pc, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);
        uncond  = 1'b1;
        address = 32'h1;
        #1;
        chk("equal_taken", taken, 1'b1);
        set_idle();

`ifdef PC_SEQ_BRCNT_EN
        do_reset();
        chk("brcnt_rst", br_count, 32'd0);
        for (int i = 0; i < 5; i++) begin
            jump_to(32'h50 + i * 4);
        end
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("brcnt_five", br_count, 32'd5);
        en     = 1'b0;
        uncond = 1'b1;
        step();
        chk("brcnt_stall", br_count, 32'd5);
        set_idle();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
